// File: rtl/p_sa_hs_pkg.sv
// Shared types for the 4-phase handshake arbiter: FSM state encoding and xid width helper.
package p_sa_hs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p_sa_hs_arb_ctrl_sync.sv
// 3-stage async-clear synchronizer; d reaches q after 3 clk edges, no backpressure.
module p_sa_hs_arb_ctrl_sync (
  input  logic clk,
  input  logic clr_,
  input  logic d,
  output logic q
);

  logic [2:0] ff;

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) ff <= 3'b000;
    else       ff <= {ff[1:0], d};
  end

  assign q = ff[2];

endmodule

// File: rtl/p_sa_hs_arb_ctrl.sv
// Round-robin arbiter driving a 4-phase req/ack handshake into another clock domain; one transfer in flight,
// requesters wait (req held) until their gnt pulse. P_SA_HS_ARB_TIMEOUT_EN adds the handshake wait timeout.
module p_sa_hs_arb_ctrl
  import p_sa_hs_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DW     = 8,
  parameter int TO_CYC = 255
) (
  input  logic                 clk,
  input  logic                 clr_,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 xreq,
  output logic [DW-1:0]        xdata,
  output logic [idw(NREQ)-1:0] xid,
  input  logic                 xack,
  output logic                 busy,
  input  logic                 err_clr,
  output logic                 timeout_err
);

  localparam int IDW = idw(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  state_t         state;
  logic           xack_s;
  logic [IDW-1:0] ptr;
  logic [1:0]     settle;
  logic [IDW-1:0] win;
  logic           win_vld;
  logic [DW-1:0]  win_data;
  int             pos;

`ifdef P_SA_HS_ARB_TIMEOUT_EN
  localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);
  logic [CW-1:0] cnt;
  logic          abort;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  p_sa_hs_arb_ctrl_sync u_sync (
    .clk  (clk),
    .clr_ (clr_),
    .d    (xack),
    .q    (xack_s)
  );

  // Lowest rotation distance from ptr wins; later loop iterations override earlier ones.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    win_data = '0;
    pos      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (i == pos && req[i]) begin
          win      = IDW'(i);
          win_vld  = 1'b1;
          win_data = req_data[i*DW +: DW];
        end
      end
    end
  end

  // settle holds off arbitration until the synchronizer has flushed real xack
  // values, so an ack still high from before reset is seen as stale.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state       <= IDLE;
      xreq        <= 1'b0;
      xdata       <= '0;
      xid         <= '0;
      gnt         <= '0;
      busy        <= 1'b0;
      ptr         <= '0;
      settle      <= 2'd0;
      timeout_err <= 1'b0;
`ifdef P_SA_HS_ARB_TIMEOUT_EN
      cnt         <= '0;
      abort       <= 1'b0;
`endif
    end else begin
      gnt <= '0;
      if (settle != 2'd3) settle <= settle + 2'd1;
`ifdef P_SA_HS_ARB_TIMEOUT_EN
      cnt <= cnt + CW'(1);
      if (err_clr) timeout_err <= 1'b0;
`else
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_vld && !xack_s && settle == 2'd3) begin
            xdata <= win_data;
            xid   <= win;
            xreq  <= 1'b1;
            busy  <= 1'b1;
            state <= ASSERT;
`ifdef P_SA_HS_ARB_TIMEOUT_EN
            cnt   <= '0;
            abort <= 1'b0;
`endif
          end
        end
        ASSERT: begin
          if (xack_s) begin
            xreq  <= 1'b0;
            state <= RELEASE;
`ifdef P_SA_HS_ARB_TIMEOUT_EN
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            xreq        <= 1'b0;
            abort       <= 1'b1;
            state       <= RELEASE;
            cnt         <= '0;
`endif
          end
        end
        RELEASE: begin
          if (!xack_s) begin
`ifdef P_SA_HS_ARB_TIMEOUT_EN
            if (abort) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gnt   <= NREQ'(1) << xid;
              state <= DONE;
            end
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
`else
            gnt   <= NREQ'(1) << xid;
            state <= DONE;
`endif
          end
        end
        DONE: begin
          ptr   <= (xid == LAST) ? '0 : xid + 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p_sa_hs_arb_ctrl.sv
// Randomized bench for p_sa_hs_arb_ctrl with a round-robin scoreboard and a behavioural remote responder.
module tb_p_sa_hs_arb_ctrl;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 16;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              clr_;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              xreq;
  logic [DW-1:0]     xdata;
  logic [IDW-1:0]    xid;
  logic              xack;
  logic              busy;
  logic              err_clr;
  logic              timeout_err;

  p_sa_hs_arb_ctrl #(.NREQ(NREQ), .DW(DW), .TO_CYC(TO)) dut (
    .clk         (clk),
    .clr_        (clr_),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .xreq        (xreq),
    .xdata       (xdata),
    .xid         (xid),
    .xack        (xack),
    .busy        (busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int ptr_m = 0;
  int cur_id = 0;
  int rises = 0;
  int ack_dly = 2;
  bit in_flight = 1'b0;
  bit prev_xreq = 1'b0;
  bit mon_en = 1'b1;
  bit auto_ack = 1'b1;
  bit rand_ack = 1'b0;
  int grants[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first pending requester scanning up from the pointer.
  function automatic int pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return -1;
  endfunction

  task automatic observe();
    int w;
    if (mon_en && xreq && !prev_xreq) begin
      w = pick(req);
      check("one_in_flight", in_flight, 0);
      check("winner_valid", w >= 0, 1);
      check("xid_at_rise", xid, w);
      if (w >= 0) check("xdata_at_rise", xdata, req_data[w*DW +: DW]);
      check("busy_with_xreq", busy, 1);
      cur_id = w;
      in_flight = 1'b1;
      rises++;
    end
    if (mon_en && in_flight) check("xid_stable", xid, cur_id);
    if (mon_en && gnt != '0) begin
      check("gnt_expected", in_flight, 1);
      check("gnt_onehot", gnt, 64'd1 << cur_id);
      grants.push_back(cur_id);
      ptr_m = (cur_id + 1) % NREQ;
      in_flight = 1'b0;
    end
    prev_xreq = xreq;
  endtask

  task automatic respond();
    if (auto_ack && xack !== xreq) begin
      if (ack_dly <= 0) begin
        xack = xreq;
        ack_dly = rand_ack ? int'($urandom_range(0, 4)) : 2;
      end else begin
        ack_dly--;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    respond();
  endtask

  task automatic do_reset();
    clr_ = 1'b0;
    in_flight = 1'b0;
    ptr_m = 0;
    prev_xreq = 1'b0;
    rises = 0;
    ack_dly = 2;
    grants.delete();
    repeat (3) @(negedge clk);
    clr_ = 1'b1;
  endtask

  task automatic wait_gnt(input string tag, input int budget);
    int n0 = grants.size();
    int c = 0;
    while (grants.size() == n0 && c < budget) begin
      tick();
      c++;
    end
    check(tag, grants.size() > n0, 1);
  endtask

  task automatic wait_xreq(input string tag, input int budget);
    int c = 0;
    while (!xreq && c < budget) begin
      tick();
      c++;
    end
    check(tag, xreq, 1);
  endtask

  task automatic rand_req(input bit drain);
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        if (!drain && $urandom_range(0, 1) == 1) req_data[i*DW +: DW] = DW'($urandom);
        else req[i] = 1'b0;
      end else if (!drain && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b1;
        req_data[i*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int hi;
    int gsum;
    int bad;
    int c;
    clr_ = 1'b0; req = '0; req_data = '0; xack = 1'b0; err_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_xreq", xreq, 0);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_xid", xid, 0);
    check("rst_xdata", xdata, 0);
    check("rst_timeout_err", timeout_err, 0);
    clr_ = 1'b1;

    // Single request, ack 2 cycles after xreq
    req = 4'b0010;
    req_data[1*DW +: DW] = 8'hA5;
    wait_gnt("single_gnt_seen", 60);
    req = '0;
    check("single_id", grants[0], 1);
    tick(); tick();
    check("single_busy_low", busy, 0);
    check("single_gnt_count", grants.size(), 1);
    check("single_rises", rises, 1);
    check("single_xid", xid, 1);
    check("single_xdata", xdata, 8'hA5);

    // Contention, all requesters held high
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
    for (int g = 0; g < 5; g++) wait_gnt("rr_gnt_seen", 100);
    for (int i = 0; i < 5; i++)
      check("rr_order", (i < grants.size()) ? grants[i] : -1, exp_rr[i]);
    req = '0;

    // Stale ack across reset release
    auto_ack = 1'b0;
    xack = 1'b1;
    req = 4'b0001;
    do_reset();
    hi = 0;
    repeat (8) begin
      tick();
      if (xreq) hi++;
    end
    check("stale_xreq_low", hi, 0);
    xack = 1'b0;
    auto_ack = 1'b1;
    wait_gnt("stale_gnt_seen", 60);
    check("stale_id", grants.size() > 0 ? grants[$] : -1, 0);
    req = '0;

    // Reset in the middle of ASSERT
    do_reset();
    req = 4'b0001;
    wait_gnt("mid_first_gnt", 60);
    req = '0;
    tick(); tick();
    auto_ack = 1'b0;
    xack = 1'b0;
    req = 4'b0101;
    wait_xreq("mid_xreq_up", 20);
    check("mid_id", xid, 2);
    #2 clr_ = 1'b0;
    #1;
    check("mid_rst_xreq", xreq, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_xid", xid, 0);
    check("mid_rst_xdata", xdata, 0);
    check("mid_rst_err", timeout_err, 0);
    check("mid_no_gnt", grants.size(), 1);
    do_reset();
    auto_ack = 1'b1;
    wait_gnt("mid_reserve_gnt", 60);
    check("mid_reserve_id", grants.size() > 0 ? grants[0] : -1, 0);

    // Randomized traffic against the round-robin model
    req = '0;
    do_reset();
    rand_ack = 1'b1;
    repeat (3000) begin
      tick();
      rand_req(1'b0);
    end
    c = 0;
    while ((req != '0 || busy) && c < 400) begin
      tick();
      rand_req(1'b1);
      c++;
    end
    check("rand_drained", (req == '0) && !busy, 1);
    check("rand_progress", grants.size() > 50, 1);
    check("rand_rises_vs_grants", rises, grants.size());
    rand_ack = 1'b0;

`ifdef P_SA_HS_ARB_TIMEOUT_EN
    do_reset();
    mon_en = 1'b0;
    auto_ack = 1'b0;
    xack = 1'b0;
    req = 4'b0001;
    wait_xreq("to_xreq_up", 20);
    hi = 1;
    gsum = 0;
    c = 0;
    while (c < 60) begin
      tick();
      if (gnt != '0) gsum++;
      if (!xreq) break;
      hi++;
      c++;
    end
    check("to_xreq_len", hi, TO);
    check("to_err_set", timeout_err, 1);
    check("to_xreq_low", xreq, 0);
    req = '0;
    repeat (6) begin
      tick();
      if (gnt != '0) gsum++;
    end
    check("to_no_gnt", gsum, 0);
    check("to_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check("to_err_cleared", timeout_err, 0);
    mon_en = 1'b1;
    auto_ack = 1'b1;
`else
    do_reset();
    auto_ack = 1'b0;
    xack = 1'b0;
    req = 4'b0001;
    wait_xreq("noto_xreq_up", 20);
    bad = 0;
    repeat (1000) begin
      err_clr = $urandom_range(0, 1) == 1;
      tick();
      if (!xreq || timeout_err) bad++;
    end
    err_clr = 1'b0;
    check("noto_hold_errors", bad, 0);
    check("noto_xreq", xreq, 1);
    check("noto_err", timeout_err, 0);
    auto_ack = 1'b1;
    wait_gnt("noto_late_gnt", 60);
    req = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/p_sa_hs_arb_ctrl.md
P_SA_HS_ARB_CTRL -- requirements
Module: p_sa_hs_arb_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- NREQ, default 4, number of local requesters.
- DW, default 8, payload width.
- TO_CYC, default 255, timeout limit in cycles.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock.
- clr_  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester level request.
- req_data  in  NREQ*DW  payload; slice i belongs to requester i.
- gnt  out  NREQ  one-cycle completion pulse, one-hot.
- xreq  out  1  4-phase request level to the remote domain.
- xdata  out  DW  payload to the remote domain.
- xid  out  max(1,clog2(NREQ))  index of the winning requester.
- xack  in  1  asynchronous acknowledge from the remote domain.
- busy  out  1  high when the FSM is not in IDLE.
- err_clr  in  1  clears timeout_err.
- timeout_err  out  1  sticky timeout flag.
REQ-003 Every output SHALL be driven from a register.

Function
REQ-004 xack SHALL pass through a 3-flop synchronizer before use; its output is xack_s, 3 cycles of latency.
REQ-005 FSM states SHALL be IDLE, ASSERT, RELEASE and DONE.
REQ-006 IDLE with req!=0 SHALL select a winner by round-robin, starting at the index after the last granted requester; after reset, start at index 0.
- On the selecting edge, latch xdata and xid, set xreq=1, go to ASSERT.
REQ-007 ASSERT: when xack_s=1, set xreq=0 and go to RELEASE; otherwise hold.
REQ-008 RELEASE: when xack_s=0, go to DONE.
REQ-009 DONE SHALL pulse gnt[xid] for exactly 1 cycle, update the round-robin pointer, and return to IDLE.
REQ-010 xdata and xid SHALL stay stable from xreq rise until DONE exits.
REQ-011 A requester SHALL hold req and its data until its gnt pulse; deasserting req mid-transfer SHALL NOT abort the transfer.
REQ-012 At most one transfer SHALL be in flight; a new arbitration happens no earlier than the cycle after DONE.
REQ-013 A requester whose req is still high after its gnt SHALL be served again only after the other pending requesters (fairness).
REQ-014 xack_s=1 while in IDLE SHALL be ignored; IDLE waits for xack_s=0 before asserting xreq.
REQ-015 busy SHALL be 1 in ASSERT, RELEASE and DONE.

Reset
REQ-016 On clr_=0, asynchronously:
- state=IDLE, xreq=0, xdata=0, xid=0, gnt=0, busy=0, timeout_err=0.
- Round-robin pointer and synchronizer flops = 0.
REQ-017 Reset mid-transfer SHALL abandon the transfer with no gnt; the remote side sees xreq fall.

Configuration
REQ-018 Macro P_SA_HS_ARB_TIMEOUT_EN. When defined:
- A wait counter counts cycles in ASSERT and in RELEASE, cleared on each state entry.
- When the counter reaches TO_CYC in ASSERT: set timeout_err, force xreq=0, go to RELEASE; no gnt is issued for that transfer.
- RELEASE timeout: set timeout_err and go to IDLE, no gnt.
- err_clr=1 clears timeout_err; a timeout in the same cycle wins.
REQ-019 When P_SA_HS_ARB_TIMEOUT_EN is undefined: no counter is built, timeout_err is tied to 0, err_clr is ignored, and the FSM waits indefinitely.

Structure
REQ-020 Package p_sa_hs_pkg SHALL hold the FSM state enum and the IDW=max(1,clog2(NREQ)) helper function.
REQ-021 The xack synchronizer SHALL be the team's existing 3-stage async-clear synchronizer cell, instantiated once with clr_ wired to its clear; no other sub-modules.

Verification
REQ-022 Single request: req=4'b0010, data1=8'hA5, remote acks 2 cycles after xreq -> xreq rises, xid=1, xdata=A5, gnt=4'b0010 pulses exactly once, busy returns to 0.
REQ-023 Contention: req=4'b1111 held -> grant order 0,1,2,3,0; each gnt is one-hot and one cycle.
REQ-024 Stale ack: xack=1 at reset release with req=4'b0001 -> xreq stays 0 until xack_s=0.
REQ-025 Reset mid-ASSERT: pull clr_ low -> xreq=0 and all outputs 0 immediately, no gnt; after release, the pending req is re-served from index 0.
REQ-026 Timeout: with P_SA_HS_ARB_TIMEOUT_EN and TO_CYC=16, xack held 0 -> after 16 cycles in ASSERT, timeout_err=1 and xreq=0, no gnt; err_clr pulse -> timeout_err=0.
REQ-027 Without P_SA_HS_ARB_TIMEOUT_EN, xack held 0 for 1000 cycles -> xreq stays 1 and timeout_err stays 0.
